prio_event_encoder: RTL and testbench

- Parametrised, registered successor to the team's 8-bit combinational priority encoder.
- Captures single-cycle event pulses on N request lines into sticky pending bits. Selects one pending, unmasked line per transfer, either fixed-priority (MSB wins) or round-robin. Presents its index on a valid/ready output channel.
- Sits between interrupt/event sources and a consumer FSM that services one event index at a time.

---
 rtl/prio_event_encoder.sv | 161 ++++++++++++++++
 tb/tb_prio_event_encoder.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/prio_event_encoder.sv
// prio_event_encoder: registered, parametrised event priority encoder.
// Captures single-cycle request pulses into sticky pending bits. On each
// free output slot it picks one pending, unmasked line and presents its
// index on a valid/ready channel. The pick is fixed priority (highest index
// wins) or round-robin. A line re-requested while still pending, and not
// being taken on that edge, raises a one-cycle overflow pulse.
// Optional build macro PRIO_EVENT_ENCODER_DROP_CNT_EN adds a saturating
// 16-bit count of overflow pulses, together with a synchronous clear input.
module prio_event_encoder #(
  parameter int N       = 8,
  parameter int RR_MODE = 0,
  localparam int W      = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         rst,
`ifdef PRIO_EVENT_ENCODER_DROP_CNT_EN
  input  logic         drop_clr_i,
  output logic [15:0]  drop_cnt_o,
`endif
  input  logic [N-1:0] req_i,
  input  logic [N-1:0] mask_i,
  output logic [W-1:0] idx_o,
  output logic         valid_o,
  input  logic         ready_i,
  output logic [N-1:0] pending_o,
  output logic         overflow_o
);

  // Returns the found flag in the MSB and the highest set index of vec in
  // the low W bits. The index bits are zero when no bit is set.
  function automatic logic [W:0] find_highest(input logic [N-1:0] vec);
    logic [W:0] res;
    res = {(W+1){1'b0}};
    for (int k = 0; k < N; k++) begin
      if (vec[k]) begin
        res = {1'b1, W'(k)};
      end
    end
    return res;
  endfunction

  // State registers
  logic [N-1:0] pending_r;
  logic         valid_r;
  logic [W-1:0] idx_r;
  logic         overflow_r;
  logic [W-1:0] rr_ptr_r;

  // Selection datapath
  logic         load_s;
  logic [N-1:0] cand_s;
  logic [N-1:0] below_s;
  logic [N-1:0] cand_lo_s;
  logic [W:0]   hit_lo_s;
  logic [W:0]   hit_all_s;
  logic         cand_any_s;
  logic [W-1:0] win_s;
  logic [N-1:0] take_s;

  // The output slot can take a new index when it is empty or being accepted.
  // Candidates are the pending lines that are currently eligible.
  always_comb begin
    load_s = !valid_r || ready_i;
    cand_s = pending_r & mask_i;
  end

  // Round-robin splits the candidates into those strictly below the pointer
  // (searched first, highest first) and the rest. Searching the low group
  // first and then the whole set gives a descending search from rr_ptr-1
  // that wraps to N-1. When the pointer is zero the low group is empty, so
  // the first search after reset is plain fixed priority.
  always_comb begin
    for (int k = 0; k < N; k++) begin
      below_s[k] = (k < int'(rr_ptr_r));
    end
    if (RR_MODE != 0) begin
      cand_lo_s = cand_s & below_s;
    end else begin
      cand_lo_s = {N{1'b0}};
    end
  end

  // Pick the winner. It comes from the low group if that group has any
  // candidate, otherwise from the whole candidate set.
  always_comb begin
    hit_lo_s   = find_highest(cand_lo_s);
    hit_all_s  = find_highest(cand_s);
    cand_any_s = hit_all_s[W];
    if (hit_lo_s[W]) begin
      win_s = hit_lo_s[W-1:0];
    end else begin
      win_s = hit_all_s[W-1:0];
    end
  end

  // One-hot mask of the pending bit consumed on this edge. It is zero unless
  // a new index is actually loaded.
  always_comb begin
    for (int k = 0; k < N; k++) begin
      take_s[k] = load_s && cand_any_s && (win_s == W'(k));
    end
  end

  // Pending capture (a new request beats the clear of the same bit),
  // overflow detection, output channel and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_r  <= {N{1'b0}};
      valid_r    <= 1'b0;
      idx_r      <= {W{1'b0}};
      overflow_r <= 1'b0;
      rr_ptr_r   <= {W{1'b0}};
    end else begin
      pending_r  <= req_i | (pending_r & ~take_s);
      overflow_r <= |(req_i & pending_r & ~take_s);
      if (load_s) begin
        if (cand_any_s) begin
          idx_r   <= win_s;
          valid_r <= 1'b1;
          if (RR_MODE != 0) begin
            rr_ptr_r <= win_s;
          end else begin
            rr_ptr_r <= {W{1'b0}};
          end
        end else begin
          // Nothing eligible: drop valid and keep the last index visible.
          valid_r <= 1'b0;
        end
      end else begin
        // Backpressured: the presented index and valid stay frozen.
        valid_r <= valid_r;
      end
    end
  end

  assign pending_o  = pending_r;
  assign valid_o    = valid_r;
  assign idx_o      = idx_r;
  assign overflow_o = overflow_r;

`ifdef PRIO_EVENT_ENCODER_DROP_CNT_EN
  logic [15:0] drop_cnt_r;

  // Count the cycles in which overflow is asserted. The count saturates at
  // all-ones, and a clear in the same cycle as an increment wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt_r <= 16'h0000;
    end else if (drop_clr_i) begin
      drop_cnt_r <= 16'h0000;
    end else if (overflow_r && (drop_cnt_r != 16'hFFFF)) begin
      drop_cnt_r <= drop_cnt_r + 16'h0001;
    end else begin
      drop_cnt_r <= drop_cnt_r;
    end
  end

  assign drop_cnt_o = drop_cnt_r;
`endif

endmodule

// File: tb/tb_prio_event_encoder.sv
// Bench for prio_event_encoder. It runs a fixed-priority instance and a
// round-robin instance side by side on shared stimulus, and checks both
// every cycle against a behavioural model. Directed literal checks pin the
// main scenarios, and a randomized phase follows.
module tb_prio_event_encoder;

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic [7:0] mask;
  logic       ready;
  logic       clr;

  logic [2:0] idx0, idx1;
  logic       valid0, valid1;
  logic [7:0] pend0, pend1;
  logic       ovf0, ovf1;
`ifdef PRIO_EVENT_ENCODER_DROP_CNT_EN
  logic [15:0] cnt0, cnt1;
`endif

  int n_vec = 0;
  int n_err = 0;

  prio_event_encoder #(.N(8), .RR_MODE(0)) u_fix (
    .clk(clk), .rst(rst),
`ifdef PRIO_EVENT_ENCODER_DROP_CNT_EN
    .drop_clr_i(clr), .drop_cnt_o(cnt0),
`endif
    .req_i(req), .mask_i(mask), .idx_o(idx0), .valid_o(valid0),
    .ready_i(ready), .pending_o(pend0), .overflow_o(ovf0)
  );

  prio_event_encoder #(.N(8), .RR_MODE(1)) u_rr (
    .clk(clk), .rst(rst),
`ifdef PRIO_EVENT_ENCODER_DROP_CNT_EN
    .drop_clr_i(clr), .drop_cnt_o(cnt1),
`endif
    .req_i(req), .mask_i(mask), .idx_o(idx1), .valid_o(valid1),
    .ready_i(ready), .pending_o(pend1), .overflow_o(ovf1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // ---------------- behavioural model (index 0 = fixed, 1 = round-robin)
  bit [7:0] m_pend  [2];
  bit       m_valid [2];
  bit [2:0] m_idx   [2];
  bit       m_ovf   [2];
  int       m_ptr   [2];
  int       m_cnt   [2];
  bit       m_started = 1'b0;
  bit [7:0] mc, mt;
  int       mw, mk;

  // Model state advance on each rising edge, from the rules of the design
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        m_pend[d] = 8'h00; m_valid[d] = 1'b0; m_idx[d] = 3'd0;
        m_ovf[d] = 1'b0; m_ptr[d] = 0; m_cnt[d] = 0;
      end else begin
        mc = m_pend[d] & mask;
        mt = 8'h00;
        if (!m_valid[d] || ready) begin
          if (mc != 8'h00) begin
            mw = -1;
            // Walk down from the line just below the last winner, wrapping.
            for (int i = 1; i <= 8; i++) begin
              mk = (d == 0) ? (8 - i) : ((m_ptr[d] - i + 8) % 8);
              if (mw < 0 && mc[mk]) mw = mk;
            end
            m_idx[d]   = 3'(mw);
            m_valid[d] = 1'b1;
            mt[mw]     = 1'b1;
            if (d == 1) m_ptr[d] = mw;
          end else begin
            m_valid[d] = 1'b0;
          end
        end
        if (clr) m_cnt[d] = 0;
        else if (m_ovf[d] && m_cnt[d] < 65535) m_cnt[d] = m_cnt[d] + 1;
        m_ovf[d]  = |(req & m_pend[d] & ~mt);
        m_pend[d] = req | (m_pend[d] & ~mt);
      end
    end
    m_started = 1'b1;
  end

  // Per-cycle comparison of both instances against the model
  always @(negedge clk) begin
    if (m_started) begin
      chk("fix_valid", 64'(valid0), 64'(m_valid[0]));
      chk("fix_idx",   64'(idx0),   64'(m_idx[0]));
      chk("fix_pend",  64'(pend0),  64'(m_pend[0]));
      chk("fix_ovf",   64'(ovf0),   64'(m_ovf[0]));
      chk("rr_valid",  64'(valid1), 64'(m_valid[1]));
      chk("rr_idx",    64'(idx1),   64'(m_idx[1]));
      chk("rr_pend",   64'(pend1),  64'(m_pend[1]));
      chk("rr_ovf",    64'(ovf1),   64'(m_ovf[1]));
`ifdef PRIO_EVENT_ENCODER_DROP_CNT_EN
      chk("fix_cnt", 64'(cnt0), 64'(m_cnt[0]));
      chk("rr_cnt",  64'(cnt1), 64'(m_cnt[1]));
`endif
    end
  end

  logic [2:0] prev;
  bit         have_prev;

  // Directed scenarios, then randomized traffic
  initial begin
    rst = 1'b1; req = 8'h00; mask = 8'hFF; ready = 1'b1; clr = 1'b0;
    tick();
    chk("rst_valid", 64'(valid0), 64'd0);
    chk("rst_pend",  64'(pend0),  64'd0);
    chk("rst_idx",   64'(idx0),   64'd0);
    chk("rst_ovf",   64'(ovf0),   64'd0);
    rst = 1'b0;
    tick();

    // Fixed priority drain of 8'h25
    req = 8'h25; tick(); req = 8'h00;
    chk("t1_pend", 64'(pend0), 64'h25);
    chk("t1_nov",  64'(valid0), 64'd0);
    tick(); chk("t1_idx5", 64'(idx0), 64'd5); chk("t1_v5", 64'(valid0), 64'd1);
    tick(); chk("t1_idx2", 64'(idx0), 64'd2); chk("t1_v2", 64'(valid0), 64'd1);
    tick(); chk("t1_idx0", 64'(idx0), 64'd0); chk("t1_v0", 64'(valid0), 64'd1);
    chk("t1_pend0", 64'(pend0), 64'd0);
    tick(); chk("t1_end_v", 64'(valid0), 64'd0); chk("t1_end_p", 64'(pend0), 64'd0);

    // Backpressure, re-request and masking
    ready = 1'b0; req = 8'h80; tick(); req = 8'h00;
    chk("t2_pend", 64'(pend0), 64'h80);
    tick(); chk("t2_v", 64'(valid0), 64'd1); chk("t2_idx", 64'(idx0), 64'd7);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t2_hold_v", 64'(valid0), 64'd1);
      chk("t2_hold_idx", 64'(idx0), 64'd7);
      chk("t2_hold_p", 64'(pend0), 64'd0);
    end
    req = 8'h80; tick(); req = 8'h00;
    chk("t2_repend", 64'(pend0), 64'h80); chk("t2_no_ovf", 64'(ovf0), 64'd0);
    req = 8'h80; tick(); req = 8'h00;
    chk("t2_ovf", 64'(ovf0), 64'd1); chk("t2_ovf_p", 64'(pend0), 64'h80);
    tick(); chk("t2_ovf_end", 64'(ovf0), 64'd0);
    mask = 8'h7F; ready = 1'b1; tick();
    chk("t2_acc_v", 64'(valid0), 64'd0); chk("t2_acc_p", 64'(pend0), 64'h80);
    chk("t2_acc_idx", 64'(idx0), 64'd7);
    mask = 8'hFF; tick(); tick(); tick();

    // Round-robin fairness with a held request
    req = 8'h81; have_prev = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (valid1) begin
        if (have_prev) chk("t3_rr_alt", 64'(idx1 != prev), 64'd1);
        prev = idx1; have_prev = 1'b1;
      end
    end
    req = 8'h00; tick(); tick(); tick(); tick();

    // Set beats clear on the bit being loaded
    req = 8'h08; tick(); tick(); req = 8'h00;
    chk("t4_pend3", 64'(pend0[3]), 64'd1); chk("t4_ovf", 64'(ovf0), 64'd0);
    chk("t4_v", 64'(valid0), 64'd1); chk("t4_idx", 64'(idx0), 64'd3);
    tick(); chk("t4_v2", 64'(valid0), 64'd1); chk("t4_idx2", 64'(idx0), 64'd3);
    tick(); tick();

    // Reset in the middle of a backpressured presentation
    ready = 1'b0; req = 8'h10; tick(); req = 8'h00; tick();
    req = 8'h3C; tick(); req = 8'h00;
    chk("t5_pre_v", 64'(valid0), 64'd1); chk("t5_pre_idx", 64'(idx0), 64'd4);
    chk("t5_pre_p", 64'(pend0), 64'h3C);
    rst = 1'b1; tick();
    chk("t5_v", 64'(valid0), 64'd0); chk("t5_p", 64'(pend0), 64'd0);
    chk("t5_ovf", 64'(ovf0), 64'd0); chk("t5_idx", 64'(idx0), 64'd0);
    rst = 1'b0; ready = 1'b1; tick();
    chk("t5_post_v", 64'(valid0), 64'd0); chk("t5_post_p", 64'(pend0), 64'd0);
    tick(); chk("t5_post_v2", 64'(valid1), 64'd0);

`ifdef PRIO_EVENT_ENCODER_DROP_CNT_EN
    // Drop counter: three overflows, then a clear colliding with a fourth
    ready = 1'b0; mask = 8'h00; req = 8'h01; tick();
    for (int i = 0; i < 3; i++) tick();
    req = 8'h00; tick();
    chk("t6_cnt3", 64'(cnt0), 64'd3);
    req = 8'h01; tick(); req = 8'h00;
    chk("t6_ovf4", 64'(ovf0), 64'd1);
    clr = 1'b1; tick(); clr = 1'b0;
    chk("t6_clr", 64'(cnt0), 64'd0);
    tick(); chk("t6_clr2", 64'(cnt1), 64'd0);
    mask = 8'hFF; ready = 1'b1; tick(); tick();
`endif

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      req   = 8'($urandom) & 8'($urandom) & 8'($urandom);
      mask  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
      ready = ($urandom_range(0, 9) < 7);
      clr   = ($urandom_range(0, 99) == 0);
      rst   = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst = 1'b0; req = 8'h00; clr = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
